// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its ID-side consumers.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  // Opcodes the predictor decodes out of IF/ID.
  localparam logic [6:0]  J_FORMAT  = 7'b1101111;
  localparam logic [6:0]  B_FORMAT  = 7'b1100011;

  typedef enum logic {BOOT, RUN} fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: a bubble beats a load; with neither asserted it holds.
module if_id_register
  import fetch_pkg::*;
#(
  parameter int                 PC_SIZE  = 12,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_bubble,
  input  logic [31:0]        i_instr,
  input  logic [PC_SIZE-1:0] i_pc,
  input  logic [PC_SIZE-1:0] i_next_pc,
  output logic               o_valid,
  output logic [31:0]        o_instr,
  output logic [PC_SIZE-1:0] o_pc,
  output logic [PC_SIZE-1:0] o_next_pc
);

  logic               r_valid_p0;
  logic [31:0]        r_instr_p0;
  logic [PC_SIZE-1:0] r_pc_p0;
  logic [PC_SIZE-1:0] r_next_pc_p0;

  // IF -> ID boundary
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_p0   <= 1'b0;
      r_instr_p0   <= NOP_INSTR;
      r_pc_p0      <= RESET_PC;
      r_next_pc_p0 <= RESET_PC + PC_SIZE'(PC_STEP);
    end else if (i_bubble) begin
      r_valid_p0   <= 1'b0;
      r_instr_p0   <= NOP_INSTR;
      r_pc_p0      <= i_pc;
      r_next_pc_p0 <= i_next_pc;
    end else if (i_load) begin
      r_valid_p0   <= 1'b1;
      r_instr_p0   <= i_instr;
      r_pc_p0      <= i_pc;
      r_next_pc_p0 <= i_next_pc;
    end
  end

  assign o_valid   = r_valid_p0;
  assign o_instr   = r_instr_p0;
  assign o_pc      = r_pc_p0;
  assign o_next_pc = r_next_pc_p0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN sequencing, predictor redirect/squash and perf counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                 PC_SIZE   = 12,
  parameter logic [PC_SIZE-1:0] RESET_PC  = '0,
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 stall,
  input  logic                 do_jump,
  input  logic [PC_SIZE-1:0]   predictor_jump_pc,
  input  logic                 force_nop,
  output logic [PC_SIZE-1:0]   imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic                 if_id_valid,
  output logic [31:0]          if_id_instr,
  output logic [6:0]           if_id_opcode,
  output logic [PC_SIZE-1:0]   if_id_pc,
  output logic [PC_SIZE-1:0]   if_id_next_pc,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  fetch_state_t         r_state;
  logic [PC_SIZE-1:0]   r_pc;
  logic [CNT_WIDTH-1:0] r_fetch_cnt;
  logic [CNT_WIDTH-1:0] r_redir_cnt;

  logic                 w_run;
  logic                 w_redirect;
  logic                 w_load;
  logic                 w_bubble;
  logic [PC_SIZE-1:0]   w_pc_seq;
  logic [31:0]          w_instr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_run      = (r_state == RUN);
  assign w_redirect = do_jump | force_nop;
  // Redirect outranks stall; the hazard unit never stalls an instruction that jumps.
  assign w_bubble   = w_run & w_redirect;
  assign w_load     = w_run & ~w_redirect & ~stall;
  assign w_pc_seq   = r_pc + PC_SIZE'(PC_STEP);

  // PC / control boundary
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (w_redirect) begin
            if (do_jump) begin
              r_pc        <= predictor_jump_pc;
              r_redir_cnt <= sat_inc(r_redir_cnt);
            end
          end else if (!stall) begin
            r_pc        <= w_pc_seq;
            r_fetch_cnt <= sat_inc(r_fetch_cnt);
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  if_id_register #(
    .PC_SIZE  (PC_SIZE),
    .RESET_PC (RESET_PC)
  ) u_if_id (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_load    (w_load),
    .i_bubble  (w_bubble),
    .i_instr   (imem_rdata),
    .i_pc      (r_pc),
    .i_next_pc (w_pc_seq),
    .o_valid   (if_id_valid),
    .o_instr   (w_instr),
    .o_pc      (if_id_pc),
    .o_next_pc (if_id_next_pc)
  );

  assign imem_addr      = r_pc;
  assign if_id_instr    = w_instr;
  assign if_id_opcode   = w_instr[6:0];
  assign fetch_count    = r_fetch_cnt;
  assign redirect_count = r_redir_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner-case sequences and a randomized run against a reference model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int PC_SIZE = 12;
  localparam int CW      = 4;
  localparam int PCM     = 1 << PC_SIZE;
  localparam int CMAX    = (1 << CW) - 1;

  logic                CLK = 1'b0;
  logic                RESET = 1'b1;
  logic                stall = 1'b0;
  logic                do_jump = 1'b0;
  logic                force_nop = 1'b0;
  logic [PC_SIZE-1:0]  predictor_jump_pc = '0;
  logic [PC_SIZE-1:0]  imem_addr;
  logic [31:0]         imem_rdata;
  logic                if_id_valid;
  logic [31:0]         if_id_instr;
  logic [6:0]          if_id_opcode;
  logic [PC_SIZE-1:0]  if_id_pc;
  logic [PC_SIZE-1:0]  if_id_next_pc;
  logic [CW-1:0]       fetch_count;
  logic [CW-1:0]       redirect_count;

  fetch_stage #(
    .PC_SIZE   (PC_SIZE),
    .RESET_PC  (12'h000),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .stall             (stall),
    .do_jump           (do_jump),
    .predictor_jump_pc (predictor_jump_pc),
    .force_nop         (force_nop),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .if_id_valid       (if_id_valid),
    .if_id_instr       (if_id_instr),
    .if_id_opcode      (if_id_opcode),
    .if_id_pc          (if_id_pc),
    .if_id_next_pc     (if_id_next_pc),
    .fetch_count       (fetch_count),
    .redirect_count    (redirect_count)
  );

  always #5 CLK = ~CLK;

  // Memory returns a word tagged with its own address.
  function automatic logic [31:0] tag(input int pc);
    return 32'hC0DE_0000 | 32'(pc);
  endfunction
  assign imem_rdata = tag(int'(imem_addr));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: architectural view of the fetch stage.
  int          m_pc = 0, m_idpc = 0, m_next = 4, m_fc = 0, m_rc = 0;
  bit          m_boot = 1, m_valid = 0;
  logic [31:0] m_instr = NOP_INSTR;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit dj, input bit fn, input int tgt);
    if (r) begin
      m_pc = 0; m_boot = 1; m_valid = 0; m_instr = NOP_INSTR;
      m_idpc = 0; m_next = 4; m_fc = 0; m_rc = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (dj || fn) begin
      m_valid = 0; m_instr = NOP_INSTR;
      m_idpc = m_pc; m_next = (m_pc + 4) % PCM;
      if (dj) begin
        m_pc = tgt % PCM;
        if (m_rc < CMAX) m_rc++;
      end
    end else if (!s) begin
      m_valid = 1; m_instr = tag(m_pc);
      m_idpc = m_pc; m_next = (m_pc + 4) % PCM;
      m_pc = m_next;
      if (m_fc < CMAX) m_fc++;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit dj, input bit fn, input int tgt);
    @(negedge CLK);
    RESET = r; stall = s; do_jump = dj; force_nop = fn;
    predictor_jump_pc = tgt[PC_SIZE-1:0];
    @(posedge CLK);
    model_edge(r, s, dj, fn, tgt);
    #1;
  endtask

  task automatic check_model(input string t);
    cmp({t, ".addr"},   32'(imem_addr),      32'(m_pc));
    cmp({t, ".valid"},  32'(if_id_valid),    32'(m_valid));
    cmp({t, ".instr"},  if_id_instr,         m_instr);
    cmp({t, ".opcode"}, 32'(if_id_opcode),   32'(m_instr[6:0]));
    cmp({t, ".pc"},     32'(if_id_pc),       32'(m_idpc));
    cmp({t, ".nextpc"}, 32'(if_id_next_pc),  32'(m_next));
    cmp({t, ".fcnt"},   32'(fetch_count),    32'(m_fc));
    cmp({t, ".rcnt"},   32'(redirect_count), 32'(m_rc));
  endtask

  typedef struct {
    bit rst, st, dj, fn;
    int tgt;
    int addr;
    bit valid;
    int idpc;
    int fc;
    int rc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst st dj fn tgt     addr    v  idpc    fc rc
    tbl[0]  = '{1, 0, 0, 0, 0,      'h000,  0, 'h000,  0, 0};
    tbl[1]  = '{0, 1, 1, 1, 'h300,  'h000,  0, 'h000,  0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,      'h004,  1, 'h000,  1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0,      'h008,  1, 'h004,  2, 0};
    tbl[4]  = '{0, 0, 0, 0, 0,      'h00C,  1, 'h008,  3, 0};
    tbl[5]  = '{0, 0, 0, 0, 0,      'h010,  1, 'h00C,  4, 0};
    tbl[6]  = '{0, 0, 1, 0, 'h100,  'h100,  0, 'h010,  4, 1};
    tbl[7]  = '{0, 0, 0, 0, 0,      'h104,  1, 'h100,  5, 1};
    tbl[8]  = '{0, 1, 1, 0, 'h200,  'h200,  0, 'h104,  5, 2};
    tbl[9]  = '{0, 1, 0, 0, 0,      'h200,  0, 'h104,  5, 2};
    tbl[10] = '{0, 0, 0, 0, 0,      'h204,  1, 'h200,  6, 2};
    tbl[11] = '{0, 0, 0, 1, 0,      'h204,  0, 'h204,  6, 2};
    tbl[12] = '{0, 0, 0, 0, 0,      'h208,  1, 'h204,  7, 2};
    tbl[13] = '{0, 0, 1, 1, 'h040,  'h040,  0, 'h208,  7, 3};
    tbl[14] = '{0, 0, 0, 0, 0,      'h044,  1, 'h040,  8, 3};

    for (int i = 0; i < 15; i++) begin
      logic [31:0] e_instr;
      string t;
      t = $sformatf("vec%0d", i);
      step(tbl[i].rst, tbl[i].st, tbl[i].dj, tbl[i].fn, tbl[i].tgt);
      e_instr = tbl[i].valid ? tag(tbl[i].idpc) : NOP_INSTR;
      cmp({t, ".addr"},   32'(imem_addr),      32'(tbl[i].addr));
      cmp({t, ".valid"},  32'(if_id_valid),    32'(tbl[i].valid));
      cmp({t, ".instr"},  if_id_instr,         e_instr);
      cmp({t, ".opcode"}, 32'(if_id_opcode),   32'(e_instr[6:0]));
      cmp({t, ".pc"},     32'(if_id_pc),       32'(tbl[i].idpc));
      cmp({t, ".nextpc"}, 32'(if_id_next_pc),  32'((tbl[i].idpc + 4) % PCM));
      cmp({t, ".fcnt"},   32'(fetch_count),    32'(tbl[i].fc));
      cmp({t, ".rcnt"},   32'(redirect_count), 32'(tbl[i].rc));
    end

    // Three-cycle stall holding at 0x020
    step(0, 0, 1, 0, 'h01C);
    step(0, 0, 0, 0, 0);
    cmp("stall.pre_addr", 32'(imem_addr), 32'h020);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      cmp("stall.addr",  32'(imem_addr),   32'h020);
      cmp("stall.pc",    32'(if_id_pc),    32'h01C);
      cmp("stall.valid", 32'(if_id_valid), 32'h1);
      check_model("stall");
    end
    step(0, 0, 0, 0, 0);
    cmp("stall.resume_pc",   32'(if_id_pc),  32'h020);
    cmp("stall.resume_addr", 32'(imem_addr), 32'h024);

    // PC wraps from 0xFFC to 0x000
    step(0, 0, 1, 0, 'hFF8);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    cmp("wrap.addr",   32'(imem_addr),     32'h000);
    cmp("wrap.pc",     32'(if_id_pc),      32'hFFC);
    cmp("wrap.nextpc", 32'(if_id_next_pc), 32'h000);
    check_model("wrap");

    // Reset mid-stream overrides a simultaneous redirect
    step(1, 1, 1, 1, 'h300);
    cmp("rst.addr",   32'(imem_addr),      32'h000);
    cmp("rst.valid",  32'(if_id_valid),    32'h0);
    cmp("rst.instr",  if_id_instr,         NOP_INSTR);
    cmp("rst.pc",     32'(if_id_pc),       32'h000);
    cmp("rst.nextpc", 32'(if_id_next_pc),  32'h004);
    cmp("rst.fcnt",   32'(fetch_count),    32'h0);
    cmp("rst.rcnt",   32'(redirect_count), 32'h0);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      bit r, s, dj, fn;
      int tgt;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 25);
      dj  = ($urandom_range(0, 99) < 10);
      fn  = ($urandom_range(0, 99) < 10);
      tgt = int'($urandom_range(0, PCM / 4 - 1)) * 4;
      step(r, s, dj, fn, tgt);
      check_model($sformatf("rnd%0d", i));
    end

    // Counter saturation
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    cmp("sat.fcnt", 32'(fetch_count), 32'(CMAX));
    check_model("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined core, directly upstream of the jump predictor.
- Owns the PC register and drives the instruction-memory address.
- Registers the fetched instruction into the IF/ID pipeline register. The predictor in ID consumes the IF/ID opcode and PCs.
- Applies the predictor's redirect (do_jump, predictor_jump_pc) and squash (force_nop). Keeps saturating fetch and redirect counters for performance analysis.

Parameters:
- PC_SIZE, 12, width of all PC/address signals; byte addressing, wraps modulo 2**PC_SIZE.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold request; freezes PC and IF/ID.
- do_jump  in  1  predictor redirect request.
- predictor_jump_pc  in  PC_SIZE  redirect target.
- force_nop  in  1  predictor squash request; IF/ID becomes a bubble.
- imem_addr  out  PC_SIZE  instruction-memory address; combinational equal to the PC register.
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  registered instruction word; NOP when invalid.
- if_id_opcode  out  7  equals if_id_instr[6:0].
- if_id_pc  out  PC_SIZE  PC of the IF/ID instruction (predictor current_pc).
- if_id_next_pc  out  PC_SIZE  if_id_pc+4 (predictor next_consecutive_pc).
- fetch_count  out  CNT_WIDTH  valid instructions loaded into IF/ID.
- redirect_count  out  CNT_WIDTH  accepted redirects.

Behaviour:
- Reset, sampled at the clock edge:
  - pc = RESET_PC; state = BOOT.
  - if_id_valid = 0; if_id_instr = NOP (32'h00000013); if_id_pc = RESET_PC; if_id_next_pc = RESET_PC+4.
  - Both counters = 0.
  - Reset overrides every other input.
- FSM states BOOT and RUN:
  - BOOT lasts exactly one cycle. PC holds, IF/ID stays a bubble, stall/do_jump/force_nop are ignored. Next state is RUN.
  - RUN persists until RESET.
- Per-edge priority in RUN (highest first):
  - redirect = do_jump | force_nop:
    - pc <= do_jump ? predictor_jump_pc : pc (force_nop alone holds pc).
    - IF/ID <= bubble (valid 0, NOP, if_id_pc <= pc).
    - redirect_count increments on do_jump only.
  - stall:
    - pc and all IF/ID fields hold.
    - Counters hold.
  - normal:
    - pc <= pc+4, truncated to PC_SIZE so it wraps to 0 at the top.
    - IF/ID <= {valid 1, imem_rdata, pc, pc+4}.
    - fetch_count increments.
- Redirect beats stall in the same cycle; stall is dropped for that edge. The hazard unit guarantees a stalled ID instruction cannot assert do_jump.
- do_jump and force_nop together: the jump target is taken and one bubble is inserted. Counted as one redirect.
- Latency:
  - A redirect issued at edge N fetches predictor_jump_pc during cycle N+1.
  - That instruction appears in IF/ID after edge N+1.
  - Exactly one bubble per redirect.
- Counters saturate at all-ones and never wrap.
- if_id_next_pc is registered, not derived combinationally. It wraps identically to pc.
- imem_addr is never X after reset, including during BOOT.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR constant (32'h00000013);
  - PC_STEP constant (4);
  - fetch_state_t enum {BOOT, RUN};
  - J_FORMAT and B_FORMAT opcode constants, shared with the predictor.
- One sub-module, if_id_register: holds valid/instr/pc/next_pc and takes load, bubble and hold controls. fetch_stage keeps the PC, FSM and counters.

Test Plan:
- Reset then free-run, imem returns PC-tagged words -> BOOT cycle gives if_id_valid=0. IF/ID pcs then read 0,4,8,... with fetch_count=3 after 4 post-reset cycles.
- do_jump=1, predictor_jump_pc=0x100 while pc=0x010 -> next cycle imem_addr=0x100 and IF/ID is a bubble. One cycle later if_id_pc=0x100. redirect_count=1.
- stall=1 for 3 cycles with pc=0x020 -> imem_addr stays 0x020, IF/ID unchanged, counters unchanged. Release resumes at 0x020.
- stall=1 and do_jump=1 (target 0x200) together -> redirect taken, pc=0x200, bubble inserted.
- force_nop alone at pc=0x040 -> pc stays 0x040, if_id_valid=0, redirect_count unchanged. Next fetch loads 0x040.
- pc=0xFFC with PC_SIZE=12 -> next pc=0x000, if_id_next_pc=0x000. Then RESET mid-stream returns all outputs to reset values on the next edge.
